// File: rtl/scarv_cop_aes_subword_seq.sv
// Byte-serial AES SubWord engine: steps one byte per cycle through an external
// combinational S-box and returns the reassembled word over valid/ready.
module scarv_cop_aes_subword_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic        req_inv,
  input  logic        req_rot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [7:0]  sbox_in,
  output logic        sbox_inv,
  input  logic [7:0]  sbox_out
);

  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_BYTE = 8;
  localparam int unsigned W_CNT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d;
  logic [W_WORD-1:0]   word_q, word_d;
  logic                inv_q, inv_d;
  logic [W_WORD-1:0]   res_q, res_d;
  logic [W_BYTE-1:0]   sbox_in_q, sbox_in_d;
  logic                sbox_inv_q, sbox_inv_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [W_WORD-1:0]   word_in;

  // RotWord moves byte 0 to the top and shifts the rest down one byte.
  assign word_in = req_rot ? {req_data[7:0], req_data[31:8]} : req_data;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      inv_q       <= 1'b0;
      res_q       <= '0;
      sbox_in_q   <= '0;
      sbox_inv_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      inv_q       <= inv_d;
      res_q       <= res_d;
      sbox_in_q   <= sbox_in_d;
      sbox_inv_q  <= sbox_inv_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // S-box inputs are preloaded one cycle ahead so they stay registered and
  // sit at zero whenever the engine is not stepping through a word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    inv_d       = inv_q;
    res_d       = res_q;
    sbox_in_d   = sbox_in_q;
    sbox_inv_d  = sbox_inv_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          word_d      = word_in;
          inv_d       = req_inv;
          res_d       = '0;
          cnt_d       = '0;
          sbox_in_d   = word_in[7:0];
          sbox_inv_d  = req_inv;
          req_ready_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[{cnt_q, 3'b000} +: W_BYTE] = sbox_out;
        cnt_d     = cnt_q + W_CNT'(1);
        sbox_in_d = word_q[{cnt_d, 3'b000} +: W_BYTE];
        if (cnt_q == W_CNT'(3)) begin
          sbox_in_d   = '0;
          sbox_inv_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sbox_in_d   = '0;
        sbox_inv_d  = 1'b0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = res_q;
  assign sbox_in   = sbox_in_q;
  assign sbox_inv  = sbox_inv_q;

endmodule

// File: tb/tb_scarv_cop_aes_subword_seq.sv
// Bench for the byte-serial SubWord engine, with a golden S-box built from
// GF(2^8) inversion plus the AES affine map.
module tb_scarv_cop_aes_subword_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic        req_inv;
  logic        req_rot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  sbox_in;
  logic        sbox_inv;
  logic [7:0]  sbox_out;

  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_aes_subword_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_inv   (req_inv),
    .req_rot   (req_rot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .sbox_in   (sbox_in),
    .sbox_inv  (sbox_inv),
    .sbox_out  (sbox_out)
  );

  always_comb sbox_out = sbox_inv ? inv_tab[sbox_in] : fwd_tab[sbox_in];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] d, input bit rot);
    return rot ? ((d >> 8) | (d << 24)) : d;
  endfunction

  function automatic logic [31:0] ref_subword(input logic [31:0] d, input bit inv, input bit rot);
    logic [31:0] w = rot_word(d, rot);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = inv ? inv_tab[w[8*k +: 8]] : fwd_tab[w[8*k +: 8]];
    return r;
  endfunction

  task automatic junk_inputs();
    req_valid = 1'($urandom);
    req_data  = $urandom;
    req_inv   = 1'($urandom);
    req_rot   = 1'($urandom);
  endtask

  task automatic do_req(input logic [31:0] d, input bit inv, input bit rot,
                        input logic [31:0] exp, input int hold);
    logic [31:0] w;
    logic [31:0] mask;
    w = rot_word(d, rot);
    @(negedge g_clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_data = d; req_inv = inv; req_rot = rot;
    @(posedge g_clk); #1;
    junk_inputs();
    rsp_ready = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk);
      mask = (k == 0) ? 32'h0 : (32'hffff_ffff >> (32 - 8 * k));
      chk("run_sbox_in", 32'(sbox_in), 32'(w[8*k +: 8]));
      chk("run_sbox_inv", 32'(sbox_inv), 32'(inv));
      chk("run_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("run_req_ready", 32'(req_ready), 32'd0);
      chk("run_partial", rsp_data, exp & mask);
      @(posedge g_clk); #1;
      junk_inputs();
      rsp_ready = (k < 3) ? 1'($urandom) : 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge g_clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, exp);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_sbox_idle", {23'd0, sbox_inv, sbox_in}, 32'd0);
      @(posedge g_clk); #1;
      junk_inputs();
    end
    @(negedge g_clk);
    chk("done_valid", 32'(rsp_valid), 32'd1);
    chk("done_data", rsp_data, exp);
    chk("done_sbox_idle", {23'd0, sbox_inv, sbox_in}, 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    @(negedge g_clk);
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_hold", rsp_data, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_sbox"}, {23'd0, sbox_inv, sbox_in}, 32'd0);
  endtask

  initial begin
    logic [7:0] iv;
    logic [7:0] s;
    logic [31:0] d;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
      fwd_tab[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    g_resetn  = 1'b1;
    req_valid = 1'b0;
    req_data  = 32'h0;
    req_inv   = 1'b0;
    req_rot   = 1'b0;
    rsp_ready = 1'b0;
    #2 g_resetn = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge g_clk);
    @(negedge g_clk) g_resetn = 1'b1;
    @(negedge g_clk);
    chk("rel_ready", 32'(req_ready), 32'd1);

    do_req(32'h00010253, 1'b0, 1'b0, 32'h637c77ed, 0);
    do_req(32'h00010253, 1'b0, 1'b1, 32'hed637c77, 0);
    do_req(32'h637c77ed, 1'b1, 1'b0, 32'h00010253, 10);

    // Abort after the second RUN cycle with an async mid-cycle reset.
    @(negedge g_clk);
    req_valid = 1'b1; req_data = 32'h12345678; req_inv = 1'b0; req_rot = 1'b0;
    @(posedge g_clk); #1 req_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #3 g_resetn = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge g_clk) g_resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge g_clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
    end
    do_req(32'h00000000, 1'b0, 1'b0, 32'h63636363, 0);

    for (int i = 0; i < 25; i++) begin
      bit inv;
      bit rot;
      d   = $urandom;
      inv = 1'($urandom);
      rot = 1'($urandom);
      do_req(d, inv, rot, ref_subword(d, inv, rot), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scarv_cop_aes_subword_seq.md
# scarv_cop_aes_subword_seq

Byte-serial AES SubWord engine for the SCARV coprocessor. It accepts a 32-bit word with a direction flag and an optional RotWord, then drives an external single-byte S-box instance one byte per cycle. It reassembles the four substituted bytes and returns the result over a valid/ready handshake. It is the requester end of the S-box lookup interface: it owns sequencing, and the S-box stays purely combinational.

## Interface
No parameters. Widths are fixed by AES.
- g_clk  input  1  clock; all state updates on rising edge
- g_resetn  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  engine can accept a request
- req_data  input  32  input word; byte k = req_data[8k+7:8k]
- req_inv  input  1  1 = inverse S-box, 0 = forward
- req_rot  input  1  1 = apply RotWord before substitution
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_data  output  32  substituted word
- sbox_in  output  8  byte presented to S-box
- sbox_inv  output  1  direction presented to S-box
- sbox_out  input  8  S-box result, combinational from sbox_in/sbox_inv

## Operation
- States: IDLE, RUN, DONE. A 2-bit byte counter cnt is used in RUN.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready:
    - word_q <= req_rot ? {req_data[7:0], req_data[31:8]} : req_data
    - inv_q <= req_inv
    - res_q <= 0
    - cnt <= 0
    - go to RUN
- RUN
  - sbox_in = word_q[8*cnt+7 : 8*cnt], sbox_inv = inv_q.
  - Each cycle, res_q byte cnt <= sbox_out and cnt <= cnt+1.
  - When cnt==3, the capture completes and the state goes to DONE.
  - req_ready=0.
- DONE
  - rsp_valid=1, rsp_data=res_q.
  - On rsp_ready, go to IDLE.
  - req_ready=0 in DONE: there is no overlap between response and next request.
- Outside RUN, sbox_in=8'h00 and sbox_inv=0. This avoids data-dependent toggling on the S-box inputs while idle.
- rsp_data equals res_q at all times. It holds its value after the response handshake until the next request is accepted, at which point it clears to 0.
- req_inv and req_rot are sampled only at acceptance. Changes on these inputs during RUN or DONE have no effect.
- rsp_ready asserted while the state is not DONE is ignored.
- Wrap-around: cnt wraps from 3 to 0 at the RUN→DONE transition. No fifth S-box capture occurs.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) forces state IDLE, cnt=0, word_q=0, inv_q=0, res_q=0.
- Reset output values: req_ready=1, rsp_valid=0, rsp_data=0, sbox_in=0, sbox_inv=0.
- Reset mid-RUN or mid-DONE aborts the operation. No response is produced for it.
- Latency: request accepted at edge E0 → RUN during cycles E0..E4 (4 cycles, bytes 0..3) → rsp_valid=1 from edge E4 onward.
  - This gives a 4-cycle accept-to-valid latency.
  - With rsp_ready held high, the return to IDLE occurs at E5 and the next accept is possible at E6 at the earliest.
  - Throughput is one word per 6 cycles.
- rsp_valid stays high and rsp_data stays stable until rsp_ready is sampled high.
- All outputs are functions of registered state only. There is no combinational path from req_* or rsp_ready to any output.
- The sbox_out capture uses the same-cycle combinational S-box response. The S-box must settle within one g_clk period.

## Test plan
Bench connects a golden AES S-box/inverse model to the sbox_* ports.
- Reset check: assert g_resetn=0 asynchronously mid-cycle → all outputs take their reset values immediately. After release, req_ready=1.
- Forward SubWord: req_data=32'h00010253, inv=0, rot=0 → rsp_data=32'h637c77ed, rsp_valid 4 cycles after accept. sbox_in sequence is 53,02,01,00.
- RotWord+SubWord: req_data=32'h00010253, inv=0, rot=1 → rsp_data=32'hed637c77.
- Inverse: req_data=32'h637c77ed, inv=1 → rsp_data=32'h00010253. sbox_inv=1 during all 4 RUN cycles and 0 otherwise.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE → rsp_valid and rsp_data stable, req_ready=0. Toggling req_valid, req_data and req_inv has no effect.
- Abort and reissue: assert reset after the second RUN cycle → rsp_valid never rises for that request. Then issue a new request with req_data=32'h00000000, fwd → rsp_data=32'h63636363.
